// File: rtl/clock_rate_pkg.sv
// ============================================================================
// Module      : clock_rate_pkg
// Description : Shared widths, rate/state types and terminal-count helper
//               for the clock rate sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_rate_pkg;

  localparam int CNT_W = 27;

  typedef logic [1:0] rate_t;

  localparam rate_t RATE_MAX = 2'd3;

  typedef enum logic [1:0] {
    MANUAL     = 2'd0,
    SWEEP_UP   = 2'd1,
    SWEEP_DOWN = 2'd2
  } state_t;

  // Half-period terminal count for a rate index: the 1 Hz period halves per step.
  function automatic logic [CNT_W-1:0] rate_limit(input logic [CNT_W-1:0] base,
                                                  input rate_t rate);
    logic [CNT_W-1:0] period;
    period = base + CNT_W'(1);
    return (period >> rate) - CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_rate_divider.sv
// ============================================================================
// Module      : clock_rate_divider
// Description : Shared prescaler producing a square wave and toggle tick for a
//               variable half-period limit, with synchronous restart.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_rate_divider
  import clock_rate_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             equal,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] counter;

  assign equal = (counter == limit);

  // clear wins over equal so a rate change never emits a runt toggle
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      counter <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (equal) begin
      counter <= '0;
      clk_out <= ~clk_out;
      tick    <= 1'b1;
    end else begin
      counter <= counter + CNT_W'(1);
      tick    <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clock_rate_sequencer.sv
// ============================================================================
// Module      : clock_rate_sequencer
// Description : Selects a 1/2/4/8 Hz blink rate by button stepping or by an
//               automatic ping-pong sweep. Sweep enabled by CLOCK_RATE_SWEEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_rate_sequencer
  import clock_rate_pkg::*;
#(
  parameter int BASE_DIV      = 24_999_999,
  parameter int DWELL_TOGGLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       auto_en,
  output logic       clk_out,
  output logic       tick,
  output logic [1:0] rate_sel,
  output logic [3:0] rate_onehot
);

  state_t           state;
  state_t           state_nxt;
  rate_t            rate_nxt;
  logic [3:0]       onehot_nxt;
  logic             btn_q;
  logic             btn_rise;
  logic             btn_req;
  logic             btn_req_nxt;
  logic             rate_change;
  logic             equal;
  logic [CNT_W-1:0] limit;

  assign btn_rise = btn_next & ~btn_q;
  assign limit    = rate_limit(CNT_W'(BASE_DIV), rate_sel);

`ifdef CLOCK_RATE_SWEEP_EN
  localparam logic [7:0] DWELL_LAST = 8'(DWELL_TOGGLES - 1);

  logic [7:0] dwell;
  logic [7:0] dwell_nxt;
  logic       step_req;
  logic       step_req_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell    <= '0;
      step_req <= 1'b0;
    end else begin
      dwell    <= dwell_nxt;
      step_req <= step_req_nxt;
    end
  end
`else
  logic [8:0] unused_sweep;
  assign unused_sweep = {auto_en, equal, 7'(DWELL_TOGGLES)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MANUAL;
      rate_sel    <= '0;
      rate_onehot <= 4'b0001;
      btn_q       <= 1'b0;
      btn_req     <= 1'b0;
    end else begin
      state       <= state_nxt;
      rate_sel    <= rate_nxt;
      rate_onehot <= onehot_nxt;
      btn_q       <= btn_next;
      btn_req     <= btn_req_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rate_nxt    = rate_sel;
    btn_req_nxt = 1'b0;
`ifdef CLOCK_RATE_SWEEP_EN
    dwell_nxt    = dwell;
    step_req_nxt = 1'b0;
`endif
    case (state)
      MANUAL: begin
        // rise is captured first, rate steps the following cycle
        btn_req_nxt = btn_rise;
        if (btn_req) rate_nxt = rate_sel + 2'd1;
`ifdef CLOCK_RATE_SWEEP_EN
        if (auto_en) begin
          rate_nxt    = rate_sel;
          btn_req_nxt = 1'b0;
          dwell_nxt   = '0;
          state_nxt   = (rate_sel == RATE_MAX) ? SWEEP_DOWN : SWEEP_UP;
        end
`endif
      end
`ifdef CLOCK_RATE_SWEEP_EN
      SWEEP_UP, SWEEP_DOWN: begin
        if (!auto_en) begin
          state_nxt = MANUAL;
          dwell_nxt = '0;
        end else if (step_req) begin
          if (state == SWEEP_UP) begin
            rate_nxt = rate_sel + 2'd1;
            if (rate_nxt == RATE_MAX) state_nxt = SWEEP_DOWN;
          end else begin
            rate_nxt = rate_sel - 2'd1;
            if (rate_nxt == 2'd0) state_nxt = SWEEP_UP;
          end
        end else if (equal) begin
          if (dwell == DWELL_LAST) begin
            step_req_nxt = 1'b1;
            dwell_nxt    = '0;
          end else begin
            dwell_nxt = dwell + 8'd1;
          end
        end
      end
`endif
      default: state_nxt = MANUAL;
    endcase
  end

  always_comb begin
    rate_change = (rate_nxt != rate_sel);
    onehot_nxt  = 4'b0001 << rate_nxt;
  end

  clock_rate_divider u_divider (
    .clk     (clk),
    .rst     (rst),
    .clear   (rate_change),
    .limit   (limit),
    .equal   (equal),
    .clk_out (clk_out),
    .tick    (tick)
  );

endmodule

`default_nettype wire

// File: tb/tb_clock_rate_sequencer.sv
// ============================================================================
// Module      : tb_clock_rate_sequencer
// Description : Directed self-checking bench for clock_rate_sequencer with
//               BASE_DIV=15, DWELL_TOGGLES=2 (limits 15/7/3/1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_rate_sequencer;
  import clock_rate_pkg::*;

  localparam int BASE_DIV = 15;
  localparam int DWELL    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_next;
  logic       auto_en;
  logic       clk_out;
  logic       tick;
  logic [1:0] rate_sel;
  logic [3:0] rate_onehot;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit pulse;
    int rate;
    int onehot;
    int gap;
  } vec_t;

  vec_t vecs[5];

  clock_rate_sequencer #(
    .BASE_DIV      (BASE_DIV),
    .DWELL_TOGGLES (DWELL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_next    (btn_next),
    .auto_en     (auto_en),
    .clk_out     (clk_out),
    .tick        (tick),
    .rate_sel    (rate_sel),
    .rate_onehot (rate_onehot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles_to_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < 200);
  endtask

  task automatic check_gap(input string tag, input int exp_gap);
    int   n;
    logic prev;
    cycles_to_tick(n);
    prev = clk_out;
    cycles_to_tick(n);
    chk({tag, " tick gap"}, n, exp_gap);
    chk({tag, " clk_out toggled"}, clk_out, !prev);
  endtask

  task automatic apply_pulse(input int old_rate, input int new_rate, input int exp_first);
    int n;
    btn_next = 1'b1;
    step();
    chk("rate before step", rate_sel, old_rate);
    step();
    chk("rate on change edge", rate_sel, new_rate);
    chk("clk_out cleared on change", clk_out, 0);
    chk("tick cleared on change", tick, 0);
    n = 0;
    do begin
      step();
      n++;
      if (n == 3) btn_next = 1'b0;
    end while (tick !== 1'b1 && n < 200);
    chk("first tick after change", n, exp_first);
    while (n < 3) begin
      step();
      n++;
    end
    btn_next = 1'b0;
    repeat (4) step();
    chk("held button single step", rate_sel, new_rate);
    repeat (86) step();
  endtask

  initial begin
    int n;
    vecs[0] = '{pulse: 1'b0, rate: 0, onehot: 1, gap: 16};
    vecs[1] = '{pulse: 1'b1, rate: 1, onehot: 2, gap: 8};
    vecs[2] = '{pulse: 1'b1, rate: 2, onehot: 4, gap: 4};
    vecs[3] = '{pulse: 1'b1, rate: 3, onehot: 8, gap: 2};
    vecs[4] = '{pulse: 1'b1, rate: 0, onehot: 1, gap: 16};

    rst      = 1'b1;
    btn_next = 1'b0;
    auto_en  = 1'b0;
    step();
    step();
    chk("reset tick", tick, 0);
    chk("reset clk_out", clk_out, 0);
    chk("reset rate_sel", rate_sel, 0);
    chk("reset rate_onehot", rate_onehot, 4'b0001);
    chk("reset state", 32'(dut.state), 32'(MANUAL));
    rst = 1'b0;
    cycles_to_tick(n);
    chk("first tick after reset", n, 16);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].pulse) apply_pulse(vecs[i-1].rate, vecs[i].rate, vecs[i].gap);
      chk($sformatf("vec%0d rate_sel", i), rate_sel, vecs[i].rate);
      chk($sformatf("vec%0d rate_onehot", i), rate_onehot, vecs[i].onehot);
      check_gap($sformatf("vec%0d", i), vecs[i].gap);
    end

`ifdef CLOCK_RATE_SWEEP_EN
    begin : sweep_seq
      int         got;
      int         cyc;
      logic [1:0] prev_rate;
      int         exp_rates[16];
      exp_rates = '{0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0, 0, 1, 1};
      // start right after a tick so the dwell begins with a full half-period
      cycles_to_tick(n);
      auto_en   = 1'b1;
      got       = 0;
      cyc       = 0;
      prev_rate = rate_sel;
      while (got < 16 && cyc < 2000) begin
        btn_next = ((cyc % 7) < 3);
        step();
        cyc++;
        if (rate_sel != prev_rate) begin
          chk("sweep change clk_out", clk_out, 0);
          chk("sweep change tick", tick, 0);
          prev_rate = rate_sel;
        end
        if (tick === 1'b1) begin
          chk($sformatf("sweep tick%0d rate", got), rate_sel, exp_rates[got]);
          got++;
        end
      end
      chk("sweep tick count", got, 16);
      // step_req is pending now; dropping auto_en must discard it
      auto_en  = 1'b0;
      btn_next = 1'b0;
      step();
      chk("drop auto_en rate held", rate_sel, 1);
      chk("drop auto_en state", 32'(dut.state), 32'(MANUAL));
      cycles_to_tick(n);
      chk("tick cadence kept after drop", n, 7);
      chk("rate still held", rate_sel, 1);

      auto_en = 1'b1;
      n = 0;
      while (rate_sel != 2'd2 && n < 500) begin
        step();
        n++;
      end
      chk("sweep reached rate 2", rate_sel, 2);
    end
`else
    auto_en = 1'b1;
    repeat (60) step();
    chk("auto_en ignored rate", rate_sel, 0);
    chk("auto_en ignored state", 32'(dut.state), 32'(MANUAL));
    auto_en = 1'b0;
    apply_pulse(0, 1, 8);
`endif

    step();
    step();
    rst      = 1'b1;
    btn_next = 1'b1;
    step();
    chk("mid reset rate_sel", rate_sel, 0);
    chk("mid reset clk_out", clk_out, 0);
    chk("mid reset tick", tick, 0);
    chk("mid reset rate_onehot", rate_onehot, 4'b0001);
    rst      = 1'b0;
    auto_en  = 1'b0;
    btn_next = 1'b0;
    cycles_to_tick(n);
    chk("first tick after mid reset", n, 16);
    chk("rate after mid reset", rate_sel, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
